// File: rtl/uart_block_assembler.sv
// Frames the uart_rx byte stream (command byte + BLK_BYTES data bytes) into one AES key or plaintext block.
// Optional inter-byte timeout abort is built only when UART_TIMEOUT_EN is defined.
module uart_block_assembler #(
  parameter int          BLK_BYTES    = 16,
  parameter logic [7:0]  CMD_KEY      = 8'h4B,
  parameter logic [7:0]  CMD_PT       = 8'h50,
  parameter int          TIMEOUT_CLKS = 86800
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Rx_DV,
  input  logic [7:0]             i_Rx_Byte,
  output logic                   o_Blk_DV,
  output logic                   o_Blk_Is_Key,
  output logic [8*BLK_BYTES-1:0] o_Blk_Data,
  input  logic                   i_Blk_Ready,
  output logic                   o_Busy,
  output logic                   o_Cmd_Err,
  output logic                   o_Overrun,
  output logic                   o_Timeout
);
  // state   | meaning
  // IDLE    | waiting for a command byte
  // COLLECT | shifting in data bytes of the current frame
  // HOLD    | block presented, waiting for i_Blk_Ready

  localparam int CW = $clog2(BLK_BYTES + 1);
  localparam int DW = 8 * BLK_BYTES;

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_HOLD} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   byte_cnt, byte_cnt_nxt;
  logic [DW-1:0]   blk_data, blk_data_nxt;
  logic            is_key, is_key_nxt;
  logic            cmd_err, cmd_err_nxt;
  logic            overrun, overrun_nxt;
  logic            timeout, timeout_nxt;
  logic            to_hit;

`ifdef UART_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  logic [TW-1:0] to_cnt;

  // A strobe in the limit cycle takes priority, so the limit only fires on a silent cycle.
  assign to_hit = (state == ST_COLLECT) && !i_Rx_DV && (to_cnt == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_Clock) begin
    if (i_Reset)
      to_cnt <= '0;
    else if ((state != ST_COLLECT) || i_Rx_DV || to_hit)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
      blk_data <= '0;
      is_key   <= 1'b0;
      cmd_err  <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      blk_data <= blk_data_nxt;
      is_key   <= is_key_nxt;
      cmd_err  <= cmd_err_nxt;
      overrun  <= overrun_nxt;
      timeout  <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    blk_data_nxt = blk_data;
    is_key_nxt   = is_key;
    cmd_err_nxt  = 1'b0;
    overrun_nxt  = overrun;
    timeout_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_Rx_DV) begin
          if ((i_Rx_Byte == CMD_KEY) || (i_Rx_Byte == CMD_PT)) begin
            is_key_nxt   = (i_Rx_Byte == CMD_KEY);
            byte_cnt_nxt = '0;
            state_nxt    = ST_COLLECT;
          end else begin
            cmd_err_nxt = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (i_Rx_DV) begin
          blk_data_nxt = {blk_data[DW-9:0], i_Rx_Byte};
          byte_cnt_nxt = byte_cnt + 1'b1;
          if (byte_cnt == CW'(BLK_BYTES - 1))
            state_nxt = ST_HOLD;
        end else if (to_hit) begin
          state_nxt    = ST_IDLE;
          byte_cnt_nxt = '0;
          timeout_nxt  = 1'b1;
        end
      end
      ST_HOLD: begin
        // Bytes arriving while the block is parked are lost, including on the transfer cycle.
        if (i_Rx_DV)
          overrun_nxt = 1'b1;
        if (i_Blk_Ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_Blk_DV     = (state == ST_HOLD);
  assign o_Blk_Is_Key = is_key;
  assign o_Blk_Data   = blk_data;
  assign o_Busy       = (state != ST_IDLE);
  assign o_Cmd_Err    = cmd_err;
  assign o_Overrun    = overrun;
  assign o_Timeout    = timeout;

endmodule

// File: tb/tb_uart_block_assembler.sv
// Directed bench for uart_block_assembler: key/plaintext framing, backpressure, errors, reset.
// Timeout scenario is exercised only when UART_TIMEOUT_EN is defined (TIMEOUT_CLKS overridden to 100).
module tb_uart_block_assembler;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx_dv = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         blk_dv;
  logic         blk_is_key;
  logic [127:0] blk_data;
  logic         blk_ready = 1'b0;
  logic         busy;
  logic         cmd_err;
  logic         overrun;
  logic         timeout;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  uart_block_assembler #(
`ifdef UART_TIMEOUT_EN
    .TIMEOUT_CLKS(100),
`endif
    .BLK_BYTES(16)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .i_Rx_DV(rx_dv),
    .i_Rx_Byte(rx_byte),
    .o_Blk_DV(blk_dv),
    .o_Blk_Is_Key(blk_is_key),
    .o_Blk_Data(blk_data),
    .i_Blk_Ready(blk_ready),
    .o_Busy(busy),
    .o_Cmd_Err(cmd_err),
    .o_Overrun(overrun),
    .o_Timeout(timeout)
  );

  // Drives one strobe; returns on the negedge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (blk_dv !== 1'b0) $display("FAIL reset_dv: got %b want 0", blk_dv); else passes++;
    checks++; if (blk_is_key !== 1'b0) $display("FAIL reset_is_key: got %b want 0", blk_is_key); else passes++;
    checks++; if (blk_data !== 128'h0) $display("FAIL reset_data: got %h want 0", blk_data); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if ({cmd_err, overrun, timeout} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {cmd_err, overrun, timeout}); else passes++;
  endtask

  task automatic test_key_load();
    int early = 0;
    blk_ready = 1'b1;
    send_byte(8'h4B);
    checks++; if (busy !== 1'b1) $display("FAIL key_busy: got %b want 1", busy); else passes++;
    for (int i = 0; i < 15; i++) begin
      send_byte(8'(i));
      if (blk_dv !== 1'b0) early++;
    end
    checks++; if (early !== 0) $display("FAIL key_early_dv: got %0d want 0", early); else passes++;
    send_byte(8'h0F);
    checks++; if (blk_dv !== 1'b1) $display("FAIL key_dv: got %b want 1", blk_dv); else passes++;
    checks++; if (blk_is_key !== 1'b1) $display("FAIL key_is_key: got %b want 1", blk_is_key); else passes++;
    checks++; if (blk_data !== 128'h000102030405060708090a0b0c0d0e0f)
      $display("FAIL key_data: got %h want 000102030405060708090a0b0c0d0e0f", blk_data); else passes++;
    @(negedge clk);
    checks++; if (blk_dv !== 1'b0) $display("FAIL key_dv_one_cycle: got %b want 0", blk_dv); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL key_idle: got %b want 0", busy); else passes++;
    checks++; if (blk_data !== 128'h000102030405060708090a0b0c0d0e0f)
      $display("FAIL key_data_kept: got %h", blk_data); else passes++;
    blk_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int held = 0;
    blk_ready = 1'b0;
    send_byte(8'h50);
    for (int i = 0; i < 16; i++) send_byte(8'hAA);
    for (int i = 0; i < 20; i++) begin
      if (blk_dv === 1'b1) held++;
      @(negedge clk);
    end
    checks++; if (held !== 20) $display("FAIL bp_hold_cycles: got %0d want 20", held); else passes++;
    blk_ready = 1'b1;
    checks++; if (blk_dv !== 1'b1) $display("FAIL bp_dv_transfer: got %b want 1", blk_dv); else passes++;
    checks++; if (blk_is_key !== 1'b0) $display("FAIL bp_is_key: got %b want 0", blk_is_key); else passes++;
    checks++; if (blk_data !== {16{8'hAA}}) $display("FAIL bp_data: got %h want all aa", blk_data); else passes++;
    @(negedge clk);
    blk_ready = 1'b0;
    checks++; if (blk_dv !== 1'b0) $display("FAIL bp_dv_drop: got %b want 0", blk_dv); else passes++;
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h33);
    checks++; if (cmd_err !== 1'b1) $display("FAIL bad_cmd_pulse: got %b want 1", cmd_err); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL bad_cmd_busy: got %b want 0", busy); else passes++;
    @(negedge clk);
    checks++; if (cmd_err !== 1'b0) $display("FAIL bad_cmd_one_cycle: got %b want 0", cmd_err); else passes++;
    checks++; if (blk_dv !== 1'b0) $display("FAIL bad_cmd_dv: got %b want 0", blk_dv); else passes++;
  endtask

  task automatic test_overrun();
    blk_ready = 1'b0;
    send_byte(8'h4B);
    // Command values inside a frame are ordinary data.
    send_byte(8'h50);
    send_byte(8'h4B);
    for (int i = 0; i < 14; i++) send_byte(8'h10 + 8'(i));
    checks++; if (blk_dv !== 1'b1) $display("FAIL ovr_dv: got %b want 1", blk_dv); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else passes++;
    send_byte(8'h55);
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun); else passes++;
    checks++; if (blk_data !== 128'h504b101112131415161718191a1b1c1d)
      $display("FAIL ovr_data: got %h want 504b101112131415161718191a1b1c1d", blk_data); else passes++;
    blk_ready = 1'b1;
    checks++; if ((blk_dv !== 1'b1) || (blk_is_key !== 1'b1))
      $display("FAIL ovr_transfer: got dv=%b key=%b want 1 1", blk_dv, blk_is_key); else passes++;
    @(negedge clk);
    blk_ready = 1'b0;
    checks++; if (blk_dv !== 1'b0) $display("FAIL ovr_dv_drop: got %b want 0", blk_dv); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h4B);
    for (int i = 0; i < 7; i++) send_byte(8'h60 + 8'(i));
    checks++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", busy); else passes++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({blk_dv, busy, overrun, blk_is_key, cmd_err} !== 5'b00000)
      $display("FAIL rst_mid_outputs: got %b want 00000", {blk_dv, busy, overrun, blk_is_key, cmd_err}); else passes++;
    checks++; if (blk_data !== 128'h0) $display("FAIL rst_mid_data: got %h want 0", blk_data); else passes++;
    blk_ready = 1'b1;
    send_byte(8'h50);
    for (int i = 0; i < 16; i++) send_byte(8'hF0 + 8'(i));
    checks++; if ((blk_dv !== 1'b1) || (blk_is_key !== 1'b0))
      $display("FAIL rst_mid_new_frame: got dv=%b key=%b want 1 0", blk_dv, blk_is_key); else passes++;
    checks++; if (blk_data !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff)
      $display("FAIL rst_mid_new_data: got %h want f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff", blk_data); else passes++;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

`ifdef UART_TIMEOUT_EN
  task automatic test_timeout();
    int early = 0;
    send_byte(8'h50);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      if (timeout !== 1'b0) early++;
    end
    checks++; if (early !== 0) $display("FAIL to_early: got %0d pulses want 0", early); else passes++;
    @(negedge clk);
    checks++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout); else passes++;
    checks++; if ((busy !== 1'b0) || (blk_dv !== 1'b0))
      $display("FAIL to_idle: got busy=%b dv=%b want 0 0", busy, blk_dv); else passes++;
    @(negedge clk);
    checks++; if (timeout !== 1'b0) $display("FAIL to_one_cycle: got %b want 0", timeout); else passes++;
    blk_ready = 1'b1;
    send_byte(8'h4B);
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
    checks++; if ((blk_dv !== 1'b1) || (blk_is_key !== 1'b1))
      $display("FAIL to_new_frame: got dv=%b key=%b want 1 1", blk_dv, blk_is_key); else passes++;
    checks++; if (blk_data !== 128'h202122232425262728292a2b2c2d2e2f)
      $display("FAIL to_new_data: got %h", blk_data); else passes++;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    send_byte(8'h50);
    for (int i = 0; i < 3; i++) send_byte(8'h01 + 8'(i));
    repeat (300) @(negedge clk);
    checks++; if ((busy !== 1'b1) || (timeout !== 1'b0))
      $display("FAIL nto_waiting: got busy=%b to=%b want 1 0", busy, timeout); else passes++;
    blk_ready = 1'b1;
    for (int i = 0; i < 13; i++) send_byte(8'h04 + 8'(i));
    checks++; if (blk_data !== 128'h0102030405060708090a0b0c0d0e0f10)
      $display("FAIL nto_data: got %h want 0102030405060708090a0b0c0d0e0f10", blk_data); else passes++;
    checks++; if (blk_dv !== 1'b1) $display("FAIL nto_dv: got %b want 1", blk_dv); else passes++;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_key_load();
    test_backpressure();
    test_bad_cmd();
    test_overrun();
    test_reset_mid_frame();
`ifdef UART_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
